// File: rtl/morse_symbol_buffer.sv
// morse_symbol_buffer
//
// Morse entry engine. Debounced, edge-detected key pulses build the current
// symbol. A symbol is stored as an element count plus a bit vector, where
// element i is bit i and a 1 means dash. Finished symbols are committed into
// a DEPTH-slot message buffer that the letter-decode/display logic reads.
// A commit with an empty symbol stores a length-0 slot, which marks a word gap.
// An optional idle timeout commits a non-empty symbol automatically.
//
// Ports
//   clk       system clock
//   rst       synchronous, active-high reset
//   clear     level; empties the symbol and the buffer while held
//   dot_p     one-cycle pulse: append a dot
//   dash_p    one-cycle pulse: append a dash
//   del_p     one-cycle pulse: delete the last element, or the last slot
//             when the symbol is empty
//   commit_p  one-cycle pulse: commit the current symbol
//   cur_len   number of elements in the current symbol
//   cur_bits  current elements (1 = dash); bits at or above cur_len are 0
//   msg_data  slot k at [k*SLOT_W +: SLOT_W] = {len, bits}
//   msg_cnt   number of committed slots, 0..DEPTH
//   full      msg_cnt == DEPTH (combinational)
//   sym_err   sticky: element pushed into a symbol that was already at MAX_LEN
//   ovf       sticky: commit attempted while the buffer was full
//   commit_v  one-cycle pulse: a slot was written on the previous edge
//
// Only one action happens per cycle. The priority order is
// rst > clear > commit/timeout > del > dash > dot.
// Lower-priority pulses that arrive in the same cycle are dropped.

module morse_symbol_buffer #(
    parameter int MAX_LEN     = 6,
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            clear,
    input  logic                                            dot_p,
    input  logic                                            dash_p,
    input  logic                                            del_p,
    input  logic                                            commit_p,
    output logic [$clog2(MAX_LEN+1)-1:0]                    cur_len,
    output logic [MAX_LEN-1:0]                              cur_bits,
    output logic [DEPTH*($clog2(MAX_LEN+1)+MAX_LEN)-1:0]    msg_data,
    output logic [$clog2(DEPTH+1)-1:0]                      msg_cnt,
    output logic                                            full,
    output logic                                            sym_err,
    output logic                                            ovf,
    output logic                                            commit_v
);

    localparam int LW     = $clog2(MAX_LEN + 1);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int SLOT_W = LW + MAX_LEN;
    // The idle counter keeps at least one bit, so the logic stays legal
    // when the timeout is disabled or set to 1.
    localparam int TW     = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

    logic [LW-1:0]      cur_len_q,  cur_len_d;
    logic [MAX_LEN-1:0] cur_bits_q, cur_bits_d;
    logic [SLOT_W-1:0]  slot_q [DEPTH];
    logic [SLOT_W-1:0]  slot_d [DEPTH];
    logic [CW-1:0]      msg_cnt_q,  msg_cnt_d;
    logic               sym_err_q,  sym_err_d;
    logic               ovf_q,      ovf_d;
    logic               commit_v_q, commit_v_d;
    logic [TW-1:0]      idle_q,     idle_d;

    logic               full_w;
    logic               any_pulse;
    logic               timeout_fire;

    assign full_w    = (msg_cnt_q == CW'(DEPTH));
    assign any_pulse = dot_p | dash_p | del_p | commit_p;

    // The counter has already seen TIMEOUT_CYC-1 idle cycles. This cycle is
    // the TIMEOUT_CYC-th idle one, so the commit is applied on this edge.
    always_comb begin
        timeout_fire = 1'b0;
        if (TIMEOUT_CYC > 0) begin
            timeout_fire = !clear && !any_pulse && (cur_len_q != '0) &&
                           (idle_q == TW'(TIMEOUT_CYC - 1));
        end
    end

    always_comb begin
        cur_len_d  = cur_len_q;
        cur_bits_d = cur_bits_q;
        slot_d     = slot_q;
        msg_cnt_d  = msg_cnt_q;
        sym_err_d  = sym_err_q;
        ovf_d      = ovf_q;
        commit_v_d = 1'b0;
        idle_d     = idle_q;

        if (clear) begin
            cur_len_d  = '0;
            cur_bits_d = '0;
            for (int k = 0; k < DEPTH; k++) begin
                slot_d[k] = '0;
            end
            msg_cnt_d  = '0;
            sym_err_d  = 1'b0;
            ovf_d      = 1'b0;
            idle_d     = '0;
        end else if (commit_p || timeout_fire) begin
            if (!full_w) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (CW'(k) == msg_cnt_q) begin
                        slot_d[k] = {cur_len_q, cur_bits_q};
                    end
                end
                msg_cnt_d  = msg_cnt_q + CW'(1);
                commit_v_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
            // The symbol is discarded even when the buffer is full, so the
            // operator can start the next symbol right away.
            cur_len_d  = '0;
            cur_bits_d = '0;
            sym_err_d  = 1'b0;
            idle_d     = '0;
        end else if (del_p) begin
            idle_d = '0;
            if (cur_len_q != '0) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (LW'(i) == cur_len_q - LW'(1)) begin
                        cur_bits_d[i] = 1'b0;
                    end
                end
                cur_len_d = cur_len_q - LW'(1);
                sym_err_d = 1'b0;
            end else if (msg_cnt_q != '0) begin
                // When the symbol is empty, delete reaches back into the buffer.
                for (int k = 0; k < DEPTH; k++) begin
                    if (CW'(k) == msg_cnt_q - CW'(1)) begin
                        slot_d[k] = '0;
                    end
                end
                msg_cnt_d = msg_cnt_q - CW'(1);
                ovf_d     = 1'b0;
            end
        end else if (dash_p || dot_p) begin
            idle_d = '0;
            if (cur_len_q < LW'(MAX_LEN)) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (LW'(i) == cur_len_q) begin
                        cur_bits_d[i] = dash_p;
                    end
                end
                cur_len_d = cur_len_q + LW'(1);
            end else begin
                sym_err_d = 1'b1;
            end
        end else if ((TIMEOUT_CYC > 0) && (cur_len_q != '0)) begin
            idle_d = idle_q + TW'(1);
        end else begin
            // The counter stays at zero while the symbol is empty, so a
            // timeout can never produce a word gap.
            idle_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_len_q  <= '0;
            cur_bits_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= '0;
            end
            msg_cnt_q  <= '0;
            sym_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
            commit_v_q <= 1'b0;
            idle_q     <= '0;
        end else begin
            cur_len_q  <= cur_len_d;
            cur_bits_q <= cur_bits_d;
            slot_q     <= slot_d;
            msg_cnt_q  <= msg_cnt_d;
            sym_err_q  <= sym_err_d;
            ovf_q      <= ovf_d;
            commit_v_q <= commit_v_d;
            idle_q     <= idle_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        assign msg_data[g*SLOT_W +: SLOT_W] = slot_q[g];
    end

    assign cur_len  = cur_len_q;
    assign cur_bits = cur_bits_q;
    assign msg_cnt  = msg_cnt_q;
    assign full     = full_w;
    assign sym_err  = sym_err_q;
    assign ovf      = ovf_q;
    assign commit_v = commit_v_q;

endmodule

// File: tb/tb_morse_symbol_buffer.sv
module tb_morse_symbol_buffer;

    localparam int ML = 6;
    localparam int DP = 4;
    localparam int TO = 10;
    localparam int LW = $clog2(ML + 1);
    localparam int CW = $clog2(DP + 1);
    localparam int SW = LW + ML;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clear = 1'b0, dot_p = 1'b0, dash_p = 1'b0, del_p = 1'b0, commit_p = 1'b0;
    logic [LW-1:0]    cur_len;
    logic [ML-1:0]    cur_bits;
    logic [DP*SW-1:0] msg_data;
    logic [CW-1:0]    msg_cnt;
    logic             full, sym_err, ovf, commit_v;

    int errors = 0;
    int checks = 0;

    // Reference model: the symbol is a queue of elements, and the message is
    // a queue of (len, bits) pairs.
    int sym_q[$];
    int msg_len_q[$];
    int msg_bits_q[$];
    bit m_serr, m_ovf, m_cv;
    int m_idle;

    morse_symbol_buffer #(.MAX_LEN(ML), .DEPTH(DP), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .clear(clear), .dot_p(dot_p), .dash_p(dash_p),
        .del_p(del_p), .commit_p(commit_p), .cur_len(cur_len), .cur_bits(cur_bits),
        .msg_data(msg_data), .msg_cnt(msg_cnt), .full(full), .sym_err(sym_err),
        .ovf(ovf), .commit_v(commit_v)
    );

    always #5 clk = ~clk;

    function automatic int sym_bits();
        int b = 0;
        foreach (sym_q[i]) b |= sym_q[i] << i;
        return b;
    endfunction

    task automatic m_reset();
        sym_q.delete(); msg_len_q.delete(); msg_bits_q.delete();
        m_serr = 0; m_ovf = 0; m_cv = 0; m_idle = 0;
    endtask

    task automatic m_step(input bit c, input bit dt, input bit ds, input bit dl, input bit cm);
        bit any;
        bit to;
        any = dt | ds | dl | cm;
        to  = !c && !any && sym_q.size() > 0 && m_idle == TO - 1;
        m_cv = 0;
        if (c) begin
            m_reset();
        end else if (cm || to) begin
            if (msg_len_q.size() < DP) begin
                msg_len_q.push_back(sym_q.size());
                msg_bits_q.push_back(sym_bits());
                m_cv = 1;
            end else begin
                m_ovf = 1;
            end
            sym_q.delete(); m_serr = 0; m_idle = 0;
        end else if (dl) begin
            m_idle = 0;
            if (sym_q.size() > 0) begin
                void'(sym_q.pop_back()); m_serr = 0;
            end else if (msg_len_q.size() > 0) begin
                void'(msg_len_q.pop_back()); void'(msg_bits_q.pop_back()); m_ovf = 0;
            end
        end else if (ds || dt) begin
            m_idle = 0;
            if (sym_q.size() < ML) sym_q.push_back(ds ? 1 : 0);
            else m_serr = 1;
        end else if (sym_q.size() > 0) begin
            m_idle++;
        end else begin
            m_idle = 0;
        end
    endtask

    // One clock: apply the inputs, advance the model, and return 1 ns after the edge.
    task automatic cyc(input bit c, input bit dt, input bit ds, input bit dl, input bit cm);
        clear = c; dot_p = dt; dash_p = ds; del_p = dl; commit_p = cm;
        m_step(c, dt, ds, dl, cm);
        @(posedge clk); #1;
        clear = 0; dot_p = 0; dash_p = 0; del_p = 0; commit_p = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        m_reset();
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; dot_p = 1; dash_p = 1;
        @(posedge clk); #1;
        rst = 0; dot_p = 0; dash_p = 0;
        m_reset();
        checks++; if (cur_len !== '0)  begin errors++; $display("FAIL reset_len: got %0d want 0", cur_len); end
        checks++; if (cur_bits !== '0) begin errors++; $display("FAIL reset_bits: got %b want 0", cur_bits); end
        checks++; if (msg_data !== '0) begin errors++; $display("FAIL reset_msg: got %h want 0", msg_data); end
        checks++; if (msg_cnt !== '0)  begin errors++; $display("FAIL reset_cnt: got %0d want 0", msg_cnt); end
        checks++; if ({full, sym_err, ovf, commit_v} !== 4'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {full, sym_err, ovf, commit_v});
        end
    endtask

    task automatic test_entry();
        do_reset();
        cyc(0, 0, 1, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
        checks++; if (cur_len !== 3'd3)        begin errors++; $display("FAIL entry_len: got %0d want 3", cur_len); end
        checks++; if (cur_bits !== 6'b000001)  begin errors++; $display("FAIL entry_bits: got %b want 000001", cur_bits); end
        cyc(0, 0, 0, 0, 1);
        checks++; if (msg_data[0 +: SW] !== 9'b011_000001) begin
            errors++; $display("FAIL entry_slot0: got %b want 011000001", msg_data[0 +: SW]);
        end
        checks++; if (msg_cnt !== 3'd1 || commit_v !== 1'b1 || cur_len !== '0) begin
            errors++; $display("FAIL entry_commit: got cnt=%0d cv=%b len=%0d want 1 1 0", msg_cnt, commit_v, cur_len);
        end
        cyc(0, 0, 0, 0, 0);
        checks++; if (commit_v !== 1'b0) begin errors++; $display("FAIL entry_cv_pulse: got %b want 0", commit_v); end
    endtask

    task automatic test_sym_err();
        do_reset();
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 0);
        checks++; if (cur_len !== 3'd6 || cur_bits !== '0 || sym_err !== 1'b1) begin
            errors++; $display("FAIL symerr_set: got len=%0d bits=%b err=%b want 6 0 1", cur_len, cur_bits, sym_err);
        end
        cyc(0, 0, 0, 1, 0);
        checks++; if (cur_len !== 3'd5 || sym_err !== 1'b0) begin
            errors++; $display("FAIL symerr_del: got len=%0d err=%b want 5 0", cur_len, sym_err);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DP; i++) begin cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 1); end
        checks++; if (msg_cnt !== 3'd4 || full !== 1'b1 || ovf !== 1'b0) begin
            errors++; $display("FAIL full_set: got cnt=%0d full=%b ovf=%b want 4 1 0", msg_cnt, full, ovf);
        end
        checks++; if (msg_data[3*SW +: SW] !== 9'b001_000001) begin
            errors++; $display("FAIL full_slot3: got %b want 001000001", msg_data[3*SW +: SW]);
        end
        cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 1);
        checks++; if (ovf !== 1'b1 || msg_cnt !== 3'd4 || commit_v !== 1'b0 || cur_len !== '0) begin
            errors++; $display("FAIL full_ovf: got ovf=%b cnt=%0d cv=%b len=%0d want 1 4 0 0", ovf, msg_cnt, commit_v, cur_len);
        end
        cyc(0, 0, 0, 1, 0);
        checks++; if (msg_cnt !== 3'd3 || msg_data[3*SW +: SW] !== '0 || ovf !== 1'b0 || full !== 1'b0) begin
            errors++; $display("FAIL full_del: got cnt=%0d slot3=%b ovf=%b full=%b want 3 0 0 0",
                               msg_cnt, msg_data[3*SW +: SW], ovf, full);
        end
    endtask

    task automatic test_priority();
        do_reset();
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 1);
        checks++; if (cur_len !== '0 || msg_cnt !== 3'd1 || msg_data[0 +: SW] !== 9'b001_000000) begin
            errors++; $display("FAIL prio_commit: got len=%0d cnt=%0d slot0=%b want 0 1 001000000",
                               cur_len, msg_cnt, msg_data[0 +: SW]);
        end
        cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0);
        checks++; if (cur_len !== 3'd1 || cur_bits !== 6'b000001) begin
            errors++; $display("FAIL prio_del: got len=%0d bits=%b want 1 000001", cur_len, cur_bits);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < TO - 1; i++) cyc(0, 0, 0, 0, 0);
        checks++; if (msg_cnt !== '0 || cur_len !== 3'd1) begin
            errors++; $display("FAIL to_early: got cnt=%0d len=%0d want 0 1", msg_cnt, cur_len);
        end
        cyc(0, 0, 0, 0, 0);
        checks++; if (msg_cnt !== 3'd1 || commit_v !== 1'b1 || msg_data[0 +: SW] !== 9'b001_000000) begin
            errors++; $display("FAIL to_fire: got cnt=%0d cv=%b slot0=%b want 1 1 001000000",
                               msg_cnt, commit_v, msg_data[0 +: SW]);
        end
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < TO - 1; i++) cyc(0, 0, 0, 0, 0);
        checks++; if (msg_cnt !== 3'd1) begin errors++; $display("FAIL to2_early: got cnt=%0d want 1", msg_cnt); end
        cyc(0, 0, 0, 0, 0);
        checks++; if (msg_cnt !== 3'd2 || msg_data[SW +: SW] !== 9'b010_000010) begin
            errors++; $display("FAIL to2_fire: got cnt=%0d slot1=%b want 2 010000010", msg_cnt, msg_data[SW +: SW]);
        end
        for (int i = 0; i < 2 * TO; i++) cyc(0, 0, 0, 0, 0);
        checks++; if (msg_cnt !== 3'd2) begin errors++; $display("FAIL to_no_gap: got cnt=%0d want 2", msg_cnt); end
    endtask

    task automatic test_clear();
        do_reset();
        cyc(0, 0, 0, 0, 1); cyc(0, 0, 1, 0, 0); cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        checks++; if (cur_len !== '0 || cur_bits !== '0 || msg_data !== '0 || msg_cnt !== '0) begin
            errors++; $display("FAIL clear_now: got len=%0d bits=%b cnt=%0d msg=%h want all 0", cur_len, cur_bits, msg_cnt, msg_data);
        end
        cyc(1, 1, 1, 0, 0); cyc(1, 0, 0, 0, 1);
        checks++; if (cur_len !== '0 || msg_cnt !== '0 || commit_v !== 1'b0) begin
            errors++; $display("FAIL clear_held: got len=%0d cnt=%0d cv=%b want 0 0 0", cur_len, msg_cnt, commit_v);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        cyc(0, 0, 0, 0, 1); cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
        do_reset();
        checks++; if (cur_len !== '0 || msg_cnt !== '0 || msg_data !== '0) begin
            errors++; $display("FAIL rst_mid: got len=%0d cnt=%0d msg=%h want 0", cur_len, msg_cnt, msg_data);
        end
        for (int i = 0; i < TO + 2; i++) cyc(0, 0, 0, 0, 0);
        checks++; if (msg_cnt !== '0) begin errors++; $display("FAIL rst_mid_to: got cnt=%0d want 0", msg_cnt); end
    endtask

    task automatic test_random();
        logic [LW-1:0]    e_len;
        logic [ML-1:0]    e_bits;
        logic [DP*SW-1:0] e_msg;
        logic [CW-1:0]    e_cnt;
        int               burst = 0;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            bit c, dt, ds, dl, cm;
            c = 0; dt = 0; ds = 0; dl = 0; cm = 0;
            if (burst > 0) begin
                burst--;
            end else if ($urandom_range(0, 99) < 3) begin
                burst = $urandom_range(8, 13);
            end else begin
                c  = ($urandom_range(0, 99) < 2);
                cm = ($urandom_range(0, 99) < 8);
                dl = ($urandom_range(0, 99) < 12);
                ds = ($urandom_range(0, 99) < 25);
                dt = ($urandom_range(0, 99) < 25);
            end
            cyc(c, dt, ds, dl, cm);
            e_len  = LW'(sym_q.size());
            e_bits = ML'(sym_bits());
            e_cnt  = CW'(msg_len_q.size());
            e_msg  = '0;
            foreach (msg_len_q[k]) e_msg[k*SW +: SW] = {LW'(msg_len_q[k]), ML'(msg_bits_q[k])};
            checks++; if (cur_len !== e_len)   begin errors++; $display("FAIL rnd_len @%0d: got %0d want %0d", n, cur_len, e_len); end
            checks++; if (cur_bits !== e_bits) begin errors++; $display("FAIL rnd_bits @%0d: got %b want %b", n, cur_bits, e_bits); end
            checks++; if (msg_data !== e_msg)  begin errors++; $display("FAIL rnd_msg @%0d: got %h want %h", n, msg_data, e_msg); end
            checks++; if (msg_cnt !== e_cnt)   begin errors++; $display("FAIL rnd_cnt @%0d: got %0d want %0d", n, msg_cnt, e_cnt); end
            checks++; if (full !== (msg_len_q.size() == DP)) begin
                errors++; $display("FAIL rnd_full @%0d: got %b want %b", n, full, msg_len_q.size() == DP);
            end
            checks++; if ({sym_err, ovf, commit_v} !== {m_serr, m_ovf, m_cv}) begin
                errors++; $display("FAIL rnd_flags @%0d: got %b want %b", n, {sym_err, ovf, commit_v}, {m_serr, m_ovf, m_cv});
            end
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_sym_err();
        test_full();
        test_priority();
        test_timeout();
        test_clear();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
